serial_rx: RTL
==============

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 50, giving clk cycles per serial bit; legal range is 4 or more.
REQ-002 The block SHALL have parameter CTR_SIZE, default 6, giving the bit-timer width; 2^CTR_SIZE SHALL be at least CLK_PER_BIT.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port rx, input, width 1: serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port data, output, width 8: last correctly framed byte received.
REQ-007 The block SHALL have port new_data, output, width 1: one-cycle pulse, data valid and updated.
REQ-008 The block SHALL have port framing_err, output, width 1: one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port busy, output, width 1: high whenever the state is not IDLE.

Function
REQ-010 The block SHALL pass rx through a two-flop synchronizer (rx_s) before any use; both flops SHALL reset to 1.
REQ-011 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-012 The FSM SHALL have states IDLE, START_BIT, DATA, STOP_BIT and BREAK.
REQ-013 IDLE: ctr=0 and bit_ctr=0; when rx_s=0, the FSM SHALL go to START_BIT.
REQ-014 START_BIT: ctr SHALL increment; at ctr==CLK_PER_BIT/2-1 (integer division), the FSM SHALL go to DATA with ctr=0 if rx_s=0, else return to IDLE (glitch rejected, no output pulse).
REQ-015 DATA: ctr SHALL increment; at ctr==CLK_PER_BIT-1 the block SHALL store rx_s into shift bit[bit_ctr], set ctr=0 and increment bit_ctr; after storing bit 7 it SHALL go to STOP_BIT.
REQ-016 STOP_BIT: at ctr==CLK_PER_BIT-1, if rx_s=1 the block SHALL load data from the shift register, pulse new_data the next cycle and go to IDLE.
REQ-017 STOP_BIT: at ctr==CLK_PER_BIT-1, if rx_s=0 the block SHALL leave data unchanged, pulse framing_err the next cycle and go to BREAK.
REQ-018 BREAK: the FSM SHALL stay until rx_s=1, then go to IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-019 Latency: new_data SHALL rise exactly 9*CLK_PER_BIT + CLK_PER_BIT/2 + 3 cycles after the first clk edge that samples rx low.
REQ-020 new_data and framing_err SHALL each be high for exactly one cycle per frame, and SHALL never be high together.
REQ-021 data SHALL hold its value between new_data pulses; a glitch or framing error SHALL NOT alter it.
REQ-022 A new start bit SHALL be accepted in the cycle IDLE is re-entered, supporting back-to-back frames with no idle gap.
REQ-023 Counters SHALL not wrap in legal operation; the default branch of any illegal state SHALL go to IDLE.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=IDLE, ctr=0, bit_ctr=0, shift=0, data=8'h00, new_data=0, framing_err=0, busy=0, sync flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a fresh falling edge.

Verification (bench uses CLK_PER_BIT=16, CTR_SIZE=5; bit period 16 clks)
REQ-026 Send 8'hA5, line idle before and after -> exactly one new_data pulse 155 cycles after rx falls, data=8'hA5, busy high throughout the frame.
REQ-027 Send 8'h00 then 8'hFF back-to-back with no gap -> two new_data pulses 160 cycles apart, data=8'h00 then 8'hFF.
REQ-028 Drive a 4-cycle low glitch on idle rx -> no new_data or framing_err pulse, busy returns low within 12 cycles, data unchanged.
REQ-029 Send 8'h3C with the stop bit low, then hold rx low for 100 cycles -> one framing_err pulse, no new_data pulse, data keeps its previous value, FSM stays in BREAK until rx rises, then the next valid byte 8'h81 is received correctly.
REQ-030 Assert rst_n=0 during bit 3 of a frame, release, then send 8'h5A -> no pulse from the aborted frame, all outputs at reset values, 8'h5A received with exact REQ-019 latency.

Source files
------------

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 serial byte receiver with framing-error and break handling
//
// Parameters:
//   CLK_PER_BIT : clk cycles per serial bit (>= 4)
//   CTR_SIZE    : bit-timer width, 2**CTR_SIZE >= CLK_PER_BIT
// Ports:
//   clk         : clock, all state changes on its rising edge
//   rst_n       : asynchronous active-low reset
//   rx          : serial line, asynchronous to clk, idle high
//   data        : last correctly framed byte
//   new_data    : one-cycle pulse, data has just been updated
//   framing_err : one-cycle pulse, stop bit was sampled low
//   busy        : high whenever the receiver is not idle
module serial_rx #(
    parameter int CLK_PER_BIT = 50,
    parameter int CTR_SIZE    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       framing_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3,
        BREAK     = 3'd4
    } state_t;

    localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);

    state_t              state, state_d;
    logic [CTR_SIZE-1:0] ctr, ctr_d;
    logic [2:0]          bit_ctr, bit_ctr_d;
    logic [7:0]          shift, shift_d;
    logic [7:0]          data_d;
    logic                done_d, err_d;
    logic                done_q, err_q;
    logic                rx_meta, rx_s;

    // Two-flop synchronizer; reset high so a released reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctr         <= '0;
            bit_ctr     <= '0;
            shift       <= '0;
            data        <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            new_data    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_d;
            ctr         <= ctr_d;
            bit_ctr     <= bit_ctr_d;
            shift       <= shift_d;
            data        <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            // Pulses trail the stop-bit decision by one extra stage to meet the fixed frame latency.
            new_data    <= done_q;
            framing_err <= err_q;
        end
    end

    always_comb begin
        state_d   = state;
        ctr_d     = ctr;
        bit_ctr_d = bit_ctr;
        shift_d   = shift;
        data_d    = data;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
                if (!rx_s) state_d = START_BIT;
            end
            START_BIT: begin
                // Re-check the line at mid start bit; a high level means it was a glitch.
                if (ctr == HALF_LAST) begin
                    ctr_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    ctr_d = ctr + 1'b1;
                end
            end
            DATA: begin
                if (ctr == BIT_LAST) begin
                    ctr_d            = '0;
                    shift_d[bit_ctr] = rx_s;
                    bit_ctr_d        = bit_ctr + 3'd1;
                    if (bit_ctr == 3'd7) state_d = STOP_BIT;
                end else begin
                    ctr_d = ctr + 1'b1;
                end
            end
            STOP_BIT: begin
                if (ctr == BIT_LAST) begin
                    ctr_d = '0;
                    if (rx_s) begin
                        data_d  = shift;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    ctr_d = ctr + 1'b1;
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line yields one error only.
                ctr_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                ctr_d     = '0;
                bit_ctr_d = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
